// File: rtl/oric_ram_pkg.sv
// Shared types and helpers for the port-B RAM sequencer and its verify pipeline.
package oric_ram_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      VERIFY,
      DRAIN
   } seq_state_t;

   typedef enum logic [1:0] {
      PAT_ZERO,
      PAT_ONES,
      PAT_STRIPE,
      PAT_ADDR
   } pat_mode_t;

   // Cycles from the address register loading to read data being usable here.
   localparam int RAM_RD_LAT = 2;

   // Every pattern depends only on the low address byte, so only that is passed in.
   function automatic logic [7:0] pattern_byte(input pat_mode_t mode, input logic [7:0] addr);
      logic [7:0] result;
      case (mode)
         PAT_ZERO:   result = 8'h00;
         PAT_ONES:   result = 8'hFF;
         PAT_STRIPE: result = addr[2] ? 8'hFF : 8'h00;
         PAT_ADDR:   result = addr;
         default:    result = 8'h00;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/ram_verify_pipe.sv
// Readback checker: delays issued address/expected byte to line up with RAM read data,
// counts mismatches (saturating) and records the first failing address of a run.
module ram_verify_pipe
   import oric_ram_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int ERR_W  = 16
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              clear,
   input  logic              valid,
   input  logic [ADDR_W-1:0] addr,
   input  logic [7:0]        expected,
   input  logic [7:0]        ram_q_b,
   output logic [ERR_W-1:0]  err_count,
   output logic [ADDR_W-1:0] first_err_addr
);

   logic [ADDR_W-1:0]     addr_dl [RAM_RD_LAT];
   logic [7:0]            exp_dl  [RAM_RD_LAT];
   logic [RAM_RD_LAT-1:0] vld_dl;
   logic                  seen_err;
   logic                  mismatch;

   assign mismatch = vld_dl[RAM_RD_LAT-1] && (ram_q_b != exp_dl[RAM_RD_LAT-1]);

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         vld_dl <= '0;
         for (int i = 0; i < RAM_RD_LAT; i++) begin
            addr_dl[i] <= '0;
            exp_dl[i]  <= '0;
         end
      end else begin
         vld_dl     <= clear ? '0 : {vld_dl[RAM_RD_LAT-2:0], valid};
         addr_dl[0] <= addr;
         exp_dl[0]  <= expected;
         for (int i = 1; i < RAM_RD_LAT; i++) begin
            addr_dl[i] <= addr_dl[i-1];
            exp_dl[i]  <= exp_dl[i-1];
         end
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         err_count      <= '0;
         first_err_addr <= '0;
         seen_err       <= 1'b0;
      end else if (clear) begin
         err_count      <= '0;
         first_err_addr <= '0;
         seen_err       <= 1'b0;
      end else if (mismatch) begin
         if (err_count != '1) begin
            err_count <= err_count + 1'b1;
         end
         if (!seen_err) begin
            first_err_addr <= addr_dl[RAM_RD_LAT-1];
            seen_err       <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/ram_port_b_seq.sv
// Port-B owner of the system dual-port RAM: power-on pattern fill, optional readback
// verify, and a single-outstanding read service for the video client when idle.
module ram_port_b_seq
   import oric_ram_pkg::*;
#(
   parameter int ERR_W  = 16,
   parameter int ADDR_W = 16
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        pattern_mode,
   input  logic              verify_en,
   output logic              busy,
   output logic              done,
   output logic [ERR_W-1:0]  err_count,
   output logic [ADDR_W-1:0] first_err_addr,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_ack,
   output logic [7:0]        rd_data,
   output logic [7:0]        ram_d_b,
   output logic [ADDR_W-1:0] ram_ad_b,
   output logic              ram_cs_b,
   output logic              ram_we_b,
   input  logic [7:0]        ram_q_b
);

   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

   seq_state_t        state, state_next;
   pat_mode_t         mode_q;
   logic              verify_q;
   logic [ADDR_W-1:0] addr_cnt, addr_next, addr_inc;
   logic              drain_cnt, drain_next;
   logic              busy_next, done_next;
   logic              cs_next, we_next;
   logic [ADDR_W-1:0] ad_next;
   logic [7:0]        d_next;
   logic              accept_start, accept_rd, vfy_push;
   logic [7:0]        vfy_exp;
   logic [RAM_RD_LAT:0] rd_pipe;
   logic [7:0]        rd_hold;
   logic              rd_inflight;

   assign addr_inc    = addr_cnt + 1'b1;
   assign rd_inflight = |rd_pipe;
   assign vfy_exp     = pattern_byte(mode_q, ad_next[7:0]);

   // The address counter always equals the address currently on ram_ad_b, so the
   // terminal test is a compare against all-ones rather than a wrap to zero.
   always_comb begin
      state_next   = state;
      addr_next    = addr_cnt;
      drain_next   = drain_cnt;
      busy_next    = busy;
      done_next    = 1'b0;
      cs_next      = 1'b0;
      we_next      = 1'b0;
      ad_next      = ram_ad_b;
      d_next       = ram_d_b;
      accept_start = 1'b0;
      accept_rd    = 1'b0;
      vfy_push     = 1'b0;
      case (state)
         IDLE: begin
            if (!rd_inflight && start) begin
               accept_start = 1'b1;
               state_next   = FILL;
               addr_next    = '0;
               busy_next    = 1'b1;
               cs_next      = 1'b1;
               we_next      = 1'b1;
               ad_next      = '0;
               d_next       = pattern_byte(pat_mode_t'(pattern_mode), 8'h00);
            end else if (!rd_inflight && rd_req) begin
               accept_rd = 1'b1;
               cs_next   = 1'b1;
               ad_next   = rd_addr;
            end
         end
         FILL: begin
            if (addr_cnt == ADDR_LAST) begin
               addr_next = '0;
               if (verify_q) begin
                  state_next = VERIFY;
                  cs_next    = 1'b1;
                  ad_next    = '0;
                  vfy_push   = 1'b1;
               end else begin
                  state_next = IDLE;
                  busy_next  = 1'b0;
                  done_next  = 1'b1;
               end
            end else begin
               addr_next = addr_inc;
               cs_next   = 1'b1;
               we_next   = 1'b1;
               ad_next   = addr_inc;
               d_next    = pattern_byte(mode_q, addr_inc[7:0]);
            end
         end
         VERIFY: begin
            if (addr_cnt == ADDR_LAST) begin
               state_next = DRAIN;
               drain_next = 1'b0;
            end else begin
               addr_next = addr_inc;
               cs_next   = 1'b1;
               ad_next   = addr_inc;
               vfy_push  = 1'b1;
            end
         end
         DRAIN: begin
            if (drain_cnt) begin
               state_next = IDLE;
               drain_next = 1'b0;
               busy_next  = 1'b0;
               done_next  = 1'b1;
            end else begin
               drain_next = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         addr_cnt  <= '0;
         drain_cnt <= 1'b0;
         mode_q    <= PAT_ZERO;
         verify_q  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         ram_cs_b  <= 1'b0;
         ram_we_b  <= 1'b0;
         ram_ad_b  <= '0;
         ram_d_b   <= '0;
      end else begin
         state     <= state_next;
         addr_cnt  <= addr_next;
         drain_cnt <= drain_next;
         busy      <= busy_next;
         done      <= done_next;
         ram_cs_b  <= cs_next;
         ram_we_b  <= we_next;
         ram_ad_b  <= ad_next;
         ram_d_b   <= d_next;
         if (accept_start) begin
            mode_q   <= pat_mode_t'(pattern_mode);
            verify_q <= verify_en;
         end
      end
   end

   // Read data is captured when it becomes usable, then presented together with the ack.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         rd_pipe <= '0;
         rd_hold <= '0;
         rd_ack  <= 1'b0;
         rd_data <= '0;
      end else begin
         rd_pipe <= {rd_pipe[RAM_RD_LAT-1:0], accept_rd};
         rd_ack  <= rd_pipe[RAM_RD_LAT];
         if (rd_pipe[RAM_RD_LAT-1]) begin
            rd_hold <= ram_q_b;
         end
         if (rd_pipe[RAM_RD_LAT]) begin
            rd_data <= rd_hold;
         end
      end
   end

   ram_verify_pipe #(
      .ADDR_W(ADDR_W),
      .ERR_W (ERR_W)
   ) u_verify (
      .clk_sys       (clk_sys),
      .reset         (reset),
      .clear         (accept_start),
      .valid         (vfy_push),
      .addr          (ad_next),
      .expected      (vfy_exp),
      .ram_q_b       (ram_q_b),
      .err_count     (err_count),
      .first_err_addr(first_err_addr)
   );

endmodule
